// File: rtl/ghr_checkpoint_if.sv
// Branch allocate/resolve/flush bus plus predictor training outputs of the GHR checkpoint unit.
// The master side is the pipeline front-end and back-end; the slave side is the checkpoint unit.
interface ghr_checkpoint_if #(
    parameter int HIST_BITS = 11,
    parameter int TAG_BITS  = 3
);
    logic                 alloc_valid_i;
    logic                 alloc_taken_i;
    logic                 alloc_ready_o;
    logic [TAG_BITS-1:0]  alloc_tag_o;
    logic [HIST_BITS-1:0] spec_history_o;
    logic                 resolve_valid_i;
    logic [TAG_BITS-1:0]  resolve_tag_i;
    logic                 resolve_taken_i;
    logic                 resolve_mispredict_i;
    logic [31:0]          resolve_pc_i;
    logic                 flush_i;
    logic                 upd_valid_o;
    logic [31:0]          upd_pc_o;
    logic                 upd_taken_o;
    logic [HIST_BITS-1:0] upd_history_o;
    logic [TAG_BITS:0]    occupancy_o;
    logic                 tag_err_o;

    modport master (
        output alloc_valid_i, alloc_taken_i, resolve_valid_i, resolve_tag_i,
               resolve_taken_i, resolve_mispredict_i, resolve_pc_i, flush_i,
        input  alloc_ready_o, alloc_tag_o, spec_history_o, upd_valid_o, upd_pc_o,
               upd_taken_o, upd_history_o, occupancy_o, tag_err_o
    );

    modport slave (
        input  alloc_valid_i, alloc_taken_i, resolve_valid_i, resolve_tag_i,
               resolve_taken_i, resolve_mispredict_i, resolve_pc_i, flush_i,
        output alloc_ready_o, alloc_tag_o, spec_history_o, upd_valid_o, upd_pc_o,
               upd_taken_o, upd_history_o, occupancy_o, tag_err_o
    );
endinterface

// File: rtl/ghr_checkpoint_unit.sv
// Speculative GHR with an in-order checkpoint FIFO; repairs history on mispredict/flush, trains gshare one cycle after resolve.
// Allocation stalls via alloc_ready_o when DEPTH branches are in flight; resolve is never backpressured.
module ghr_checkpoint_unit #(
    parameter int HIST_BITS = 11,
    parameter int DEPTH     = 8,
    parameter int TAG_BITS  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ghr_checkpoint_if.slave       bus
);
    localparam int                CNT_W   = TAG_BITS + 1;
    localparam logic [TAG_BITS-1:0] PTR_ONE = TAG_BITS'(1);

    logic [HIST_BITS-1:0] spec_hist_q, spec_hist_d;
    logic [HIST_BITS-1:0] cmt_hist_q,  cmt_hist_d;
    logic [TAG_BITS-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [TAG_BITS-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]     count_q,     count_d;
    logic                 upd_valid_q, upd_valid_d;
    logic [31:0]          upd_pc_q,    upd_pc_d;
    logic                 upd_taken_q, upd_taken_d;
    logic [HIST_BITS-1:0] upd_hist_q,  upd_hist_d;
    logic                 tag_err_q,   tag_err_d;
    logic [HIST_BITS-1:0] ckpt_q [DEPTH];

    logic                 full, empty, res_ok, mispredict, alloc_ok;
    logic [HIST_BITS-1:0] rd_ckpt;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign res_ok     = bus.resolve_valid_i && !empty;
    assign mispredict = res_ok && bus.resolve_mispredict_i;
    // Anything allocated alongside a flush or mispredict is on the wrong path.
    assign alloc_ok   = bus.alloc_valid_i && !full && !bus.flush_i && !mispredict;
    assign rd_ckpt    = ckpt_q[rd_ptr_q];

    always_comb begin
        spec_hist_d = spec_hist_q;
        cmt_hist_d  = cmt_hist_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        upd_valid_d = res_ok;
        upd_pc_d    = upd_pc_q;
        upd_taken_d = upd_taken_q;
        upd_hist_d  = upd_hist_q;
        tag_err_d   = tag_err_q;

        if (bus.resolve_valid_i && (empty || (bus.resolve_tag_i != rd_ptr_q)))
            tag_err_d = 1'b1;

        if (res_ok) begin
            cmt_hist_d  = (cmt_hist_q << 1) | HIST_BITS'(bus.resolve_taken_i);
            upd_pc_d    = bus.resolve_pc_i;
            upd_taken_d = bus.resolve_taken_i;
            upd_hist_d  = rd_ckpt;
        end

        if (bus.flush_i) begin
            // Committed history already includes this cycle's resolve, if any.
            spec_hist_d = cmt_hist_d;
            rd_ptr_d    = wr_ptr_q;
            count_d     = '0;
        end else if (mispredict) begin
            spec_hist_d = (rd_ckpt << 1) | HIST_BITS'(bus.resolve_taken_i);
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            wr_ptr_d    = rd_ptr_q + PTR_ONE;
            count_d     = '0;
        end else begin
            if (alloc_ok) begin
                spec_hist_d = (spec_hist_q << 1) | HIST_BITS'(bus.alloc_taken_i);
                wr_ptr_d    = wr_ptr_q + PTR_ONE;
            end
            if (res_ok)
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d = count_q + CNT_W'(alloc_ok) - CNT_W'(res_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_hist_q <= '0;
            cmt_hist_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
            upd_hist_q  <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            spec_hist_q <= spec_hist_d;
            cmt_hist_q  <= cmt_hist_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            upd_valid_q <= upd_valid_d;
            upd_pc_q    <= upd_pc_d;
            upd_taken_q <= upd_taken_d;
            upd_hist_q  <= upd_hist_d;
            tag_err_q   <= tag_err_d;
        end
    end

    // Checkpoint storage carries no reset; occupancy alone qualifies entries.
    always_ff @(posedge clk) begin
        if (alloc_ok)
            ckpt_q[wr_ptr_q] <= spec_hist_q;
    end

    assign bus.alloc_ready_o  = !full;
    assign bus.alloc_tag_o    = wr_ptr_q;
    assign bus.occupancy_o    = count_q;
    assign bus.spec_history_o = spec_hist_q;
    assign bus.upd_valid_o    = upd_valid_q;
    assign bus.upd_pc_o       = upd_pc_q;
    assign bus.upd_taken_o    = upd_taken_q;
    assign bus.upd_history_o  = upd_hist_q;
    assign bus.tag_err_o      = tag_err_q;
endmodule

// File: tb/tb_ghr_checkpoint_unit.sv
// Directed scenarios for ghr_checkpoint_unit with hand-derived expected history values.
module tb_ghr_checkpoint_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    ghr_checkpoint_if #(.HIST_BITS(11), .TAG_BITS(3)) bus ();
    ghr_checkpoint_unit #(.HIST_BITS(11), .DEPTH(8), .TAG_BITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic clr();
        bus.alloc_valid_i        = 1'b0;
        bus.alloc_taken_i        = 1'b0;
        bus.resolve_valid_i      = 1'b0;
        bus.resolve_tag_i        = '0;
        bus.resolve_taken_i      = 1'b0;
        bus.resolve_mispredict_i = 1'b0;
        bus.resolve_pc_i         = '0;
        bus.flush_i              = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clr();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (bus.spec_history_o !== 11'h000) begin n_err++; $display("FAIL rst_spec got %h exp 000", bus.spec_history_o); end
        n_cmp++; if (bus.alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", bus.alloc_ready_o); end
        n_cmp++; if (bus.alloc_tag_o !== 3'd0) begin n_err++; $display("FAIL rst_tag got %0d exp 0", bus.alloc_tag_o); end
        n_cmp++; if (bus.occupancy_o !== 4'd0) begin n_err++; $display("FAIL rst_occ got %0d exp 0", bus.occupancy_o); end
        n_cmp++; if (bus.upd_valid_o !== 1'b0 || bus.upd_taken_o !== 1'b0) begin n_err++; $display("FAIL rst_upd got v=%b t=%b exp 0/0", bus.upd_valid_o, bus.upd_taken_o); end
        n_cmp++; if (bus.upd_history_o !== 11'h000 || bus.upd_pc_o !== 32'h0) begin n_err++; $display("FAIL rst_upd_dat got h=%h pc=%h exp 0/0", bus.upd_history_o, bus.upd_pc_o); end
        n_cmp++; if (bus.tag_err_o !== 1'b0) begin n_err++; $display("FAIL rst_tag_err got %b exp 0", bus.tag_err_o); end
        cyc();
        rst_n = 1'b1;
    endtask

    // T,T,N from reset: 000 -> 001 -> 003 -> 006
    task automatic test_alloc();
        logic [2:0]  pat;
        logic [10:0] exp_h [4];
        pat = 3'b011;
        exp_h[0] = 11'h000; exp_h[1] = 11'h001; exp_h[2] = 11'h003; exp_h[3] = 11'h006;
        for (int i = 0; i < 3; i++) begin
            bus.alloc_valid_i = 1'b1;
            bus.alloc_taken_i = pat[i];
            n_cmp++; if (bus.spec_history_o !== exp_h[i]) begin n_err++; $display("FAIL alloc_spec%0d got %h exp %h", i, bus.spec_history_o, exp_h[i]); end
            n_cmp++; if (bus.alloc_tag_o !== 3'(i)) begin n_err++; $display("FAIL alloc_tag%0d got %0d exp %0d", i, bus.alloc_tag_o, i); end
            cyc();
            clr();
        end
        n_cmp++; if (bus.spec_history_o !== exp_h[3]) begin n_err++; $display("FAIL alloc_spec_end got %h exp %h", bus.spec_history_o, exp_h[3]); end
        n_cmp++; if (bus.occupancy_o !== 4'd3) begin n_err++; $display("FAIL alloc_occ got %0d exp 3", bus.occupancy_o); end
    endtask

    task automatic test_resolve();
        logic [2:0]  pat;
        logic [10:0] exp_h [3];
        pat = 3'b011;
        exp_h[0] = 11'h000; exp_h[1] = 11'h001; exp_h[2] = 11'h003;
        for (int i = 0; i < 3; i++) begin
            bus.resolve_valid_i = 1'b1;
            bus.resolve_tag_i   = 3'(i);
            bus.resolve_taken_i = pat[i];
            bus.resolve_pc_i    = 32'h0000_1000 + 32'(i * 4);
            cyc();
            clr();
            n_cmp++; if (bus.upd_valid_o !== 1'b1) begin n_err++; $display("FAIL res_vld%0d got %b exp 1", i, bus.upd_valid_o); end
            n_cmp++; if (bus.upd_history_o !== exp_h[i]) begin n_err++; $display("FAIL res_hist%0d got %h exp %h", i, bus.upd_history_o, exp_h[i]); end
            n_cmp++; if (bus.upd_taken_o !== pat[i]) begin n_err++; $display("FAIL res_taken%0d got %b exp %b", i, bus.upd_taken_o, pat[i]); end
            n_cmp++; if (bus.upd_pc_o !== 32'h0000_1000 + 32'(i * 4)) begin n_err++; $display("FAIL res_pc%0d got %h exp %h", i, bus.upd_pc_o, 32'h0000_1000 + 32'(i * 4)); end
        end
        n_cmp++; if (bus.occupancy_o !== 4'd0) begin n_err++; $display("FAIL res_occ got %0d exp 0", bus.occupancy_o); end
        cyc();
        n_cmp++; if (bus.upd_valid_o !== 1'b0) begin n_err++; $display("FAIL res_pulse got %b exp 0", bus.upd_valid_o); end
        // Speculate one more taken branch, then flush: history must fall back to committed 0x006.
        bus.alloc_valid_i = 1'b1; bus.alloc_taken_i = 1'b1;
        cyc();
        clr();
        n_cmp++; if (bus.spec_history_o !== 11'h00D) begin n_err++; $display("FAIL res_spec_pre got %h exp 00d", bus.spec_history_o); end
        bus.flush_i = 1'b1;
        cyc();
        clr();
        n_cmp++; if (bus.spec_history_o !== 11'h006) begin n_err++; $display("FAIL res_cmt got %h exp 006", bus.spec_history_o); end
        n_cmp++; if (bus.occupancy_o !== 4'd0) begin n_err++; $display("FAIL res_flush_occ got %0d exp 0", bus.occupancy_o); end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.alloc_valid_i = 1'b1; bus.alloc_taken_i = 1'b1;
            cyc();
        end
        clr();
        n_cmp++; if (bus.spec_history_o !== 11'h01F) begin n_err++; $display("FAIL mp_spec_pre got %h exp 01f", bus.spec_history_o); end
        bus.resolve_valid_i = 1'b1; bus.resolve_tag_i = 3'd0; bus.resolve_taken_i = 1'b0;
        bus.resolve_mispredict_i = 1'b1; bus.resolve_pc_i = 32'h0000_2000;
        bus.alloc_valid_i = 1'b1; bus.alloc_taken_i = 1'b1;
        cyc();
        clr();
        n_cmp++; if (bus.spec_history_o !== 11'h000) begin n_err++; $display("FAIL mp_spec got %h exp 000", bus.spec_history_o); end
        n_cmp++; if (bus.occupancy_o !== 4'd0) begin n_err++; $display("FAIL mp_occ got %0d exp 0", bus.occupancy_o); end
        n_cmp++; if (bus.alloc_tag_o !== 3'd1) begin n_err++; $display("FAIL mp_tag got %0d exp 1", bus.alloc_tag_o); end
        n_cmp++; if (bus.upd_valid_o !== 1'b1 || bus.upd_history_o !== 11'h000 || bus.upd_taken_o !== 1'b0) begin n_err++; $display("FAIL mp_upd got v=%b h=%h t=%b exp 1/000/0", bus.upd_valid_o, bus.upd_history_o, bus.upd_taken_o); end
    endtask

    // Starts at wr=rd=1 after the mispredict scenario, so the fill wraps the write pointer.
    task automatic test_full();
        logic [10:0] e;
        for (int i = 0; i < 8; i++) begin
            bus.alloc_valid_i = 1'b1; bus.alloc_taken_i = 1'b1;
            cyc();
        end
        clr();
        n_cmp++; if (bus.alloc_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready got %b exp 0", bus.alloc_ready_o); end
        n_cmp++; if (bus.occupancy_o !== 4'd8) begin n_err++; $display("FAIL full_occ got %0d exp 8", bus.occupancy_o); end
        n_cmp++; if (bus.alloc_tag_o !== 3'd1) begin n_err++; $display("FAIL full_tag got %0d exp 1", bus.alloc_tag_o); end
        bus.alloc_valid_i = 1'b1; bus.alloc_taken_i = 1'b1;
        cyc();
        clr();
        n_cmp++; if (bus.occupancy_o !== 4'd8 || bus.spec_history_o !== 11'h0FF) begin n_err++; $display("FAIL full_drop got occ=%0d spec=%h exp 8/0ff", bus.occupancy_o, bus.spec_history_o); end
        bus.resolve_valid_i = 1'b1; bus.resolve_tag_i = 3'd1; bus.resolve_taken_i = 1'b1;
        cyc();
        clr();
        n_cmp++; if (bus.occupancy_o !== 4'd7 || bus.alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL full_res got occ=%0d rdy=%b exp 7/1", bus.occupancy_o, bus.alloc_ready_o); end
        n_cmp++; if (bus.upd_history_o !== 11'h000) begin n_err++; $display("FAIL full_res_hist got %h exp 000", bus.upd_history_o); end
        for (int k = 0; k < 7; k++) begin
            bus.resolve_valid_i = 1'b1; bus.resolve_tag_i = 3'((2 + k) % 8); bus.resolve_taken_i = 1'b1;
            bus.alloc_valid_i = 1'b1; bus.alloc_taken_i = 1'b0;
            cyc();
            clr();
            e = 11'((1 << (k + 1)) - 1);
            n_cmp++; if (bus.occupancy_o !== 4'd7) begin n_err++; $display("FAIL b2b_occ%0d got %0d exp 7", k, bus.occupancy_o); end
            n_cmp++; if (bus.upd_history_o !== e) begin n_err++; $display("FAIL b2b_hist%0d got %h exp %h", k, bus.upd_history_o, e); end
        end
        n_cmp++; if (bus.alloc_tag_o !== 3'd0) begin n_err++; $display("FAIL b2b_wrap got %0d exp 0", bus.alloc_tag_o); end
        n_cmp++; if (bus.tag_err_o !== 1'b0) begin n_err++; $display("FAIL b2b_tag_err got %b exp 0", bus.tag_err_o); end
    endtask

    // Commits 1,0,1,0,... ten times to build committed history 0x2AA, then flushes 4 in flight.
    task automatic test_back_to_back_flush();
        logic [10:0] e;
        do_reset();
        bus.alloc_valid_i = 1'b1; bus.alloc_taken_i = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            bus.alloc_valid_i = 1'b1; bus.alloc_taken_i = 1'b1;
            bus.resolve_valid_i = 1'b1; bus.resolve_tag_i = 3'(i % 8);
            bus.resolve_taken_i = ((i % 2) == 0);
            cyc();
            e = 11'((1 << i) - 1);
            n_cmp++; if (bus.upd_valid_o !== 1'b1 || bus.upd_history_o !== e) begin n_err++; $display("FAIL bb_hist%0d got v=%b h=%h exp 1/%h", i, bus.upd_valid_o, bus.upd_history_o, e); end
        end
        clr();
        n_cmp++; if (bus.occupancy_o !== 4'd1) begin n_err++; $display("FAIL bb_occ got %0d exp 1", bus.occupancy_o); end
        for (int i = 0; i < 3; i++) begin
            bus.alloc_valid_i = 1'b1; bus.alloc_taken_i = 1'b0;
            cyc();
        end
        clr();
        n_cmp++; if (bus.occupancy_o !== 4'd4) begin n_err++; $display("FAIL fl_occ_pre got %0d exp 4", bus.occupancy_o); end
        bus.flush_i = 1'b1;
        bus.resolve_valid_i = 1'b1; bus.resolve_tag_i = 3'd2; bus.resolve_taken_i = 1'b1;
        bus.alloc_valid_i = 1'b1; bus.alloc_taken_i = 1'b1;
        cyc();
        clr();
        n_cmp++; if (bus.spec_history_o !== 11'h555) begin n_err++; $display("FAIL fl_spec got %h exp 555", bus.spec_history_o); end
        n_cmp++; if (bus.upd_valid_o !== 1'b1 || bus.upd_history_o !== 11'h3FF) begin n_err++; $display("FAIL fl_upd got v=%b h=%h exp 1/3ff", bus.upd_valid_o, bus.upd_history_o); end
        n_cmp++; if (bus.occupancy_o !== 4'd0 || bus.alloc_tag_o !== 3'd6) begin n_err++; $display("FAIL fl_ptr got occ=%0d tag=%0d exp 0/6", bus.occupancy_o, bus.alloc_tag_o); end
        cyc();
        n_cmp++; if (bus.upd_valid_o !== 1'b0) begin n_err++; $display("FAIL fl_pulse got %b exp 0", bus.upd_valid_o); end
    endtask

    task automatic test_tag_err();
        do_reset();
        bus.alloc_valid_i = 1'b1; bus.alloc_taken_i = 1'b1;
        cyc();
        clr();
        n_cmp++; if (bus.tag_err_o !== 1'b0) begin n_err++; $display("FAIL te_pre got %b exp 0", bus.tag_err_o); end
        bus.resolve_valid_i = 1'b1; bus.resolve_tag_i = 3'd5; bus.resolve_taken_i = 1'b1;
        cyc();
        clr();
        n_cmp++; if (bus.tag_err_o !== 1'b1 || bus.upd_valid_o !== 1'b1) begin n_err++; $display("FAIL te_wrong got err=%b v=%b exp 1/1", bus.tag_err_o, bus.upd_valid_o); end
        n_cmp++; if (bus.occupancy_o !== 4'd0) begin n_err++; $display("FAIL te_occ got %0d exp 0", bus.occupancy_o); end
        bus.resolve_valid_i = 1'b1; bus.resolve_tag_i = 3'd1; bus.resolve_taken_i = 1'b1;
        cyc();
        clr();
        n_cmp++; if (bus.upd_valid_o !== 1'b0 || bus.occupancy_o !== 4'd0) begin n_err++; $display("FAIL te_empty got v=%b occ=%0d exp 0/0", bus.upd_valid_o, bus.occupancy_o); end
        repeat (3) cyc();
        n_cmp++; if (bus.tag_err_o !== 1'b1) begin n_err++; $display("FAIL te_sticky got %b exp 1", bus.tag_err_o); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (bus.tag_err_o !== 1'b0) begin n_err++; $display("FAIL te_reset got %b exp 0", bus.tag_err_o); end
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        clr();
        test_reset();
        test_alloc();
        test_resolve();
        test_mispredict();
        test_full();
        test_back_to_back_flush();
        test_tag_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
